// File: rtl/gelu_arb_pkg.sv
// gelu_arb_pkg: shared data width, port id and tag-stage types for the GELU arbiter
package gelu_arb_pkg;
    localparam int DATA_W = 8;
    typedef logic port_t;
    typedef struct packed {
        logic  valid;
        port_t port;
    } tag_t;
endpackage

// File: rtl/gelu_arb_fifo.sv
// gelu_arb_fifo: per-requester result buffer, power-of-two depth, wrapping pointers
// Ports: clk, reset (async, active-high); wr/wdata push; rd pops head when non-empty;
//        rdata = head entry (0 while in reset); count = current occupancy 0..DEPTH
module gelu_arb_fifo
    import gelu_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    rd,
    output logic [DATA_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_rd;
    assign do_rd = rd && count != '0;
    assign rdata = reset ? '0 : mem[rptr];
    always_ff @(posedge clk)
        if (wr) mem[wptr] <= wdata;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(wr) - (AW+1)'(do_rd);
        end
    end
    // the issuing side reserves a slot per operand before it is accepted, so a full write is a bug
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr && count == (AW+1)'(DEPTH)));
endmodule

// File: rtl/gelu_arbiter.sv
// gelu_arbiter: round-robin sharing of one pipelined GELU unit between two requesters
// Ports: clk, reset (async, active-high); req0/1 valid/data/ready operand inputs;
//        act_x registered operand to the unit, act_y result LAT cycles later;
//        rsp0/1 valid/data/ready in-order results per requester.
// Option: define GELU_ARB_STATS_EN to add saturating 16-bit issue_cnt0/issue_cnt1 outputs.
module gelu_arbiter
    import gelu_arb_pkg::*;
#(
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic [DATA_W-1:0] act_x,
    input  logic [DATA_W-1:0] act_y,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic [DATA_W-1:0] rsp1_data,
    input  logic              rsp0_ready,
    input  logic              rsp1_ready
`ifdef GELU_ARB_STATS_EN
    ,
    output logic [15:0]       issue_cnt0,
    output logic [15:0]       issue_cnt1
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    tag_t pipe [LAT+1];
    logic [CW-1:0] count0, count1, inflight0, inflight1;
    logic credit0, credit1, elig0, elig1, acc0, acc1, wr0, wr1;
    port_t last_grant;
    // a slot is reserved for every operand still in the unit, so buffered + in-flight never exceeds depth
    assign credit0 = (count0 + inflight0) < DEPTH_C;
    assign credit1 = (count1 + inflight1) < DEPTH_C;
    assign elig0   = req0_valid && credit0;
    assign elig1   = req1_valid && credit1;
    // ready looks only at credit, last grant and the other side's request, never at rsp_ready
    assign req0_ready = !reset && credit0 && (!elig1 || last_grant == 1'b1);
    assign req1_ready = !reset && credit1 && (!elig0 || last_grant == 1'b0);
    assign acc0 = req0_valid && req0_ready;
    assign acc1 = req1_valid && req1_ready;
    assign wr0  = pipe[LAT].valid && pipe[LAT].port == 1'b0;
    assign wr1  = pipe[LAT].valid && pipe[LAT].port == 1'b1;
    assign rsp0_valid = count0 != '0;
    assign rsp1_valid = count1 != '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_x      <= '0;
            last_grant <= 1'b1;
            inflight0  <= '0;
            inflight1  <= '0;
            for (int i = 0; i <= LAT; i++) pipe[i] <= '0;
        end else begin
            if (acc0 || acc1) begin
                act_x      <= acc0 ? req0_data : req1_data;
                last_grant <= acc1;
            end
            pipe[0] <= '{valid: acc0 || acc1, port: acc1};
            for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
            inflight0 <= inflight0 + CW'(acc0) - CW'(wr0);
            inflight1 <= inflight1 + CW'(acc1) - CW'(wr1);
        end
    end
    gelu_arb_fifo #(.DEPTH(FIFO_DEPTH)) fifo0 (
        .clk(clk), .reset(reset), .wr(wr0), .wdata(act_y),
        .rd(rsp0_ready), .rdata(rsp0_data), .count(count0)
    );
    gelu_arb_fifo #(.DEPTH(FIFO_DEPTH)) fifo1 (
        .clk(clk), .reset(reset), .wr(wr1), .wdata(act_y),
        .rd(rsp1_ready), .rdata(rsp1_data), .count(count1)
    );
`ifdef GELU_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (acc0 && issue_cnt0 != 16'hFFFF) issue_cnt0 <= issue_cnt0 + 16'd1;
            if (acc1 && issue_cnt1 != 16'hFFFF) issue_cnt1 <= issue_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gelu_arbiter.sv
// tb_gelu_arbiter: scoreboard bench for two arbiter instances (LAT=1/depth 4 and LAT=3/depth 8)
module tb_gelu_arbiter;
    typedef struct {
        logic [7:0] y;
        int         c;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic v0 [2], v1 [2], rr0 [2], rr1 [2];
    logic [7:0] dd0 [2], dd1 [2];
    logic r0 [2], r1 [2], rv0 [2], rv1 [2];
    logic [7:0] ax [2], ay [2], rd0 [2], rd1 [2];
`ifdef GELU_ARB_STATS_EN
    logic [15:0] ic0 [2], ic1 [2];
`endif
    logic [7:0] lut [256];
    logic [7:0] yp [2][3];
    exp_t q [4][$];
    int glog [2][$];
    int acc [4], pops [4];
    bit lat_chk [2];
    int cyc = 0, checks = 0, errors = 0;

    gelu_arbiter #(.LAT(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(reset),
        .req0_valid(v0[0]), .req1_valid(v1[0]),
        .req0_data(dd0[0]), .req1_data(dd1[0]),
        .req0_ready(r0[0]), .req1_ready(r1[0]),
        .act_x(ax[0]), .act_y(ay[0]),
        .rsp0_valid(rv0[0]), .rsp1_valid(rv1[0]),
        .rsp0_data(rd0[0]), .rsp1_data(rd1[0]),
        .rsp0_ready(rr0[0]), .rsp1_ready(rr1[0])
`ifdef GELU_ARB_STATS_EN
        , .issue_cnt0(ic0[0]), .issue_cnt1(ic1[0])
`endif
    );
    gelu_arbiter #(.LAT(3), .FIFO_DEPTH(8)) dut1 (
        .clk(clk), .reset(reset),
        .req0_valid(v0[1]), .req1_valid(v1[1]),
        .req0_data(dd0[1]), .req1_data(dd1[1]),
        .req0_ready(r0[1]), .req1_ready(r1[1]),
        .act_x(ax[1]), .act_y(ay[1]),
        .rsp0_valid(rv0[1]), .rsp1_valid(rv1[1]),
        .rsp0_data(rd0[1]), .rsp1_data(rd1[1]),
        .rsp0_ready(rr0[1]), .rsp1_ready(rr1[1])
`ifdef GELU_ARB_STATS_EN
        , .issue_cnt0(ic0[1]), .issue_cnt1(ic1[1])
`endif
    );

    // stand-in GELU unit: LAT register stages from act_x to act_y
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            yp[d][0] <= lut[ax[d]];
            yp[d][1] <= yp[d][0];
            yp[d][2] <= yp[d][1];
        end
    end
    assign ay[0] = yp[0][0];
    assign ay[1] = yp[1][2];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic issue(input int d, input int p, input logic [7:0] x);
        q[2*d+p].push_back('{y: lut[x], c: cyc});
        glog[d].push_back(p);
        acc[2*d+p]++;
    endtask

    task automatic retire(input int d, input int p, input logic [7:0] got);
        exp_t e;
        int k;
        k = 2*d + p;
        pops[k]++;
        if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp%0d_dut%0d_unexpected: got %0d, want no response", p, d, got);
        end else begin
            e = q[k].pop_front();
            chk($sformatf("rsp%0d_dut%0d_data", p, d), got, e.y);
            if (lat_chk[d]) chk($sformatf("rsp%0d_dut%0d_latency", p, d), cyc - e.c, (d == 0 ? 1 : 3) + 2);
        end
    endtask

    // monitor: inputs settle 1 time unit after each rising edge, so the falling edge sees the handshake
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                q[2*d].delete();
                q[2*d+1].delete();
            end else begin
                if (v0[d] && r0[d]) issue(d, 0, dd0[d]);
                if (v1[d] && r1[d]) issue(d, 1, dd1[d]);
                if (rv0[d] && rr0[d]) retire(d, 0, rd0[d]);
                if (rv1[d] && rr1[d]) retire(d, 1, rd1[d]);
            end
        end
    end

    function automatic int gl(input int d, input int i);
        return i < glog[d].size() ? glog[d][i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_chk(input string t);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_req0_ready_%0d", t, d), r0[d], 0);
            chk($sformatf("%s_req1_ready_%0d", t, d), r1[d], 0);
            chk($sformatf("%s_rsp0_valid_%0d", t, d), rv0[d], 0);
            chk($sformatf("%s_rsp1_valid_%0d", t, d), rv1[d], 0);
            chk($sformatf("%s_act_x_%0d", t, d), ax[d], 0);
            chk($sformatf("%s_rsp0_data_%0d", t, d), rd0[d], 0);
            chk($sformatf("%s_rsp1_data_%0d", t, d), rd1[d], 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int a0, a1, p0, stalls;
        // reference GELU on Q4.4 operands: y = x * sigmoid(1.702 x), rounded to Q4.4
        for (int i = 0; i < 256; i++) begin
            real xr, yr;
            xr = real'(i < 128 ? i : i - 256) / 16.0;
            yr = xr / (1.0 + $exp(-1.702 * xr));
            lut[i] = 8'(int'(yr * 16.0));
        end
        for (int d = 0; d < 2; d++) begin
            v0[d] = 0; v1[d] = 0; dd0[d] = 0; dd1[d] = 0;
            rr0[d] = 1; rr1[d] = 1; lat_chk[d] = 1;
        end
        #1;
        reset_chk("por");
        tick(2);
        reset = 0;
        tick(1);
`ifdef GELU_ARB_STATS_EN
        chk("stats_after_reset0", ic0[0], 0);
        chk("stats_after_reset1", ic1[0], 0);
`endif
        // both ports streaming: grants alternate starting with port 0
        glog[0].delete();
        v0[0] = 1; v1[0] = 1; dd0[0] = 8'h10; dd1[0] = 8'h20;
        tick(8);
        v0[0] = 0; v1[0] = 0;
        tick(6);
        chk("rr_grant_count", glog[0].size(), 8);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant_%0d", i), gl(0, i), i % 2);
        chk("rr_rsp0_count", pops[0], 4);
        chk("rr_rsp1_count", pops[1], 4);
`ifdef GELU_ARB_STATS_EN
        chk("stats_issue_cnt0", ic0[0], 4);
        chk("stats_issue_cnt1", ic1[0], 4);
`endif
        // single port back-to-back extremes
        a0 = acc[0]; p0 = pops[0];
        v0[0] = 1; dd0[0] = 8'h80;
        tick(1);
        dd0[0] = 8'h00;
        tick(1);
        dd0[0] = 8'h7F;
        tick(1);
        v0[0] = 0;
        chk("single_accepts_per_cycle", acc[0] - a0, 3);
        tick(6);
        chk("single_rsp_count", pops[0] - p0, 3);
        // port 1 backpressured: credit runs out at depth 4, port 0 keeps going
        lat_chk[0] = 0; rr1[0] = 0;
        a0 = acc[0]; a1 = acc[1];
        v0[0] = 1; v1[0] = 1; dd0[0] = 8'h30;
        for (int i = 0; i < 12; i++) begin
            dd1[0] = 8'(8'h40 + i);
            tick(1);
        end
        chk("bp_port1_accepts", acc[1] - a1, 4);
        chk("bp_port0_accepts", acc[0] - a0, 8);
        chk("bp_req1_ready", r1[0], 0);
        chk("bp_req0_ready", r0[0], 1);
        a1 = acc[1];
        rr1[0] = 1;
        tick(1);
        rr1[0] = 0;
        tick(6);
        chk("bp_one_more_accept", acc[1] - a1, 1);
        chk("bp_req1_ready_again", r1[0], 0);
        v0[0] = 0; v1[0] = 0; rr1[0] = 1;
        tick(10);
        chk("bp_drain_q0", q[0].size(), 0);
        chk("bp_drain_q1", q[1].size(), 0);
        lat_chk[0] = 1;
        // LAT=3 sweep of every operand on port 0
        a0 = acc[2]; p0 = pops[2]; stalls = 0;
        v0[1] = 1;
        for (int x = -128; x < 128; x++) begin
            dd0[1] = 8'(x);
            while (!r0[1] && stalls < 50) begin
                stalls++;
                tick(1);
            end
            tick(1);
        end
        v0[1] = 0;
        chk("sweep_stalls", stalls, 0);
        tick(10);
        chk("sweep_accepts", acc[2] - a0, 256);
        chk("sweep_responses", pops[2] - p0, 256);
        // reset with 3 in flight and 2 buffered on the LAT=3 instance
        lat_chk[1] = 0; rr0[1] = 0; rr1[1] = 0;
        a0 = acc[2] + acc[3];
        v0[1] = 1; v1[1] = 1; dd0[1] = 8'h05; dd1[1] = 8'hF0;
        tick(5);
        v0[1] = 0; v1[1] = 0;
        tick(1);
        chk("mid_accepts", acc[2] + acc[3] - a0, 5);
        chk("mid_rsp0_buffered", rv0[1], 1);
        chk("mid_rsp1_buffered", rv1[1], 1);
        #2;
        reset = 1;
        #1;
        reset_chk("mid");
        tick(2);
        reset = 0;
        glog[1].delete();
`ifdef GELU_ARB_STATS_EN
        chk("mid_stats_cnt0", ic0[1], 0);
        chk("mid_stats_cnt1", ic1[1], 0);
`endif
        tick(8);
        chk("post_rsp0_valid", rv0[1], 0);
        chk("post_rsp1_valid", rv1[1], 0);
        lat_chk[1] = 1; rr0[1] = 1; rr1[1] = 1;
        v0[1] = 1; v1[1] = 1; dd0[1] = 8'h11; dd1[1] = 8'h22;
        tick(1);
        v0[1] = 0; v1[1] = 0;
        chk("post_first_tie", gl(1, 0), 0);
        chk("post_tie_grants", glog[1].size(), 1);
        tick(10);
        chk("post_drain_q0", q[2].size(), 0);
        chk("post_drain_q1", q[3].size(), 0);
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
